// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue and its byte ring.
package fetch_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int BEAT_BYTES     = 8;
  localparam int BEATS_PER_LINE = LINE_BYTES / BEAT_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } fetch_state_t;

  typedef logic [14:0][7:0] fetch_win_t;

endpackage

// File: rtl/fetch_byte_ring.sv
// Circular instruction byte store: one aligned 8-byte beat write per cycle and
// a combinational, wrapping window read starting at an arbitrary byte.
module fetch_byte_ring
  import fetch_pkg::*;
#(
  parameter int BUF_BYTES = 128,
  parameter int WIN_BYTES = 15,
  localparam int AW = $clog2(BUF_BYTES),
  localparam int BW = $clog2(BEAT_BYTES)
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [AW-BW-1:0]        wr_slot_i,
  input  logic [BEAT_BYTES*8-1:0] wr_data_i,
  input  logic [AW-1:0]           rd_ptr_i,
  output logic [WIN_BYTES*8-1:0]  rd_data_o
);

  logic [7:0] mem_q [BUF_BYTES];

  // NOTE: the storage array has no reset; occupancy in the parent decides
  // which bytes are meaningful, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < BEAT_BYTES; b++) begin
        mem_q[{wr_slot_i, BW'(b)}] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Index arithmetic is AW bits wide, so the window wraps past the last byte.
  for (genvar i = 0; i < WIN_BYTES; i++) begin : g_win
    logic [AW-1:0] idx;
    assign idx = rd_ptr_i + AW'(i);
    assign rd_data_o[8*i +: 8] = mem_q[idx];
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues line reads, absorbs response beats into a
// byte ring and presents a decode window at the current RIP.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int BUF_BYTES  = 128,
  parameter int WIN_BYTES  = 15,
  parameter int LINE_BYTES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            entry,
  input  logic                   redirect,
  input  logic [63:0]            redirect_rip,
  output logic                   reqcyc,
  output logic [63:0]            req,
  input  logic                   reqack,
  input  logic                   respcyc,
  input  logic [63:0]            resp,
  output logic                   respack,
  output logic [WIN_BYTES*8-1:0] win_bytes,
  output logic [3:0]             win_count,
  output logic [63:0]            win_rip,
  input  logic [3:0]             consume
);

  localparam int AW        = $clog2(BUF_BYTES);
  localparam int OW        = AW + 1;
  localparam int BW        = $clog2(BEAT_BYTES);
  localparam int LW        = $clog2(LINE_BYTES);
  localparam int CW        = LW - BW;
  localparam int LAST_BEAT = LINE_BYTES / BEAT_BYTES - 1;

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [63:0]   win_rip_q, win_rip_d;
  logic [63:0]   line_rip_q, line_rip_d;
  logic [63:0]   req_addr_q, req_addr_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] skip_q, skip_d;
  logic          first_q, first_d;
  logic          stale_q, stale_d;

  logic          beat_in, last_beat, wr_en;
  logic [AW-1:0] rd_base;
  logic [OW-1:0] added;
  fetch_win_t    window;

  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    win_rip_d  = win_rip_q;
    line_rip_d = line_rip_q;
    req_addr_d = req_addr_q;
    beat_d     = beat_q;
    skip_d     = skip_q;
    first_d    = first_q;
    stale_d    = stale_q;
    wr_en      = 1'b0;
    rd_base    = rd_ptr_q;
    added      = '0;
    beat_in    = (state_q == ST_RESP) && respcyc;
    last_beat  = beat_in && (beat_q == CW'(LAST_BEAT));

    unique case (state_q)
      ST_IDLE: begin
        if (occ_q <= OW'(BUF_BYTES - LINE_BYTES) && !redirect) begin
          state_d    = ST_REQ;
          req_addr_d = line_rip_q;
        end
      end
      ST_REQ: begin
        if (reqack) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (beat_in) begin
          beat_d = beat_q + CW'(1);
          if (last_beat) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      win_rip_d  = redirect_rip;
      line_rip_d = redirect_rip & ~64'(LINE_BYTES - 1);
      skip_d     = redirect_rip[LW-1:BW];
      first_d    = 1'b1;
      // A line already on the bus must drain before the new one is requested.
      stale_d    = (state_q == ST_REQ) || ((state_q == ST_RESP) && !last_beat);
    end else begin
      if (beat_in && !stale_q && !(first_q && (beat_q < skip_q))) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(BEAT_BYTES);
        added    = OW'(BEAT_BYTES);
        if (first_q && (beat_q == skip_q)) begin
          rd_base = wr_ptr_q + AW'(win_rip_q[BW-1:0]);
          added   = OW'(BEAT_BYTES) - OW'(win_rip_q[BW-1:0]);
        end
      end
      rd_ptr_d  = rd_base + AW'(consume);
      occ_d     = occ_q + added - OW'(consume);
      win_rip_d = win_rip_q + 64'(consume);
      if (last_beat) begin
        if (stale_q) begin
          stale_d = 1'b0;
        end else begin
          first_d    = 1'b0;
          line_rip_d = line_rip_q + 64'(LINE_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      win_rip_q  <= entry;
      line_rip_q <= entry & ~64'(LINE_BYTES - 1);
      req_addr_q <= '0;
      beat_q     <= '0;
      skip_q     <= entry[LW-1:BW];
      first_q    <= 1'b1;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      win_rip_q  <= win_rip_d;
      line_rip_q <= line_rip_d;
      req_addr_q <= req_addr_d;
      beat_q     <= beat_d;
      skip_q     <= skip_d;
      first_q    <= first_d;
      stale_q    <= stale_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect) begin
      assert (consume <= win_count)
        else $fatal(1, "fetch_queue: consume %0d exceeds win_count %0d", consume, win_count);
    end
  end

  fetch_byte_ring #(
    .BUF_BYTES (BUF_BYTES),
    .WIN_BYTES (WIN_BYTES)
  ) u_ring (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_slot_i (wr_ptr_q[AW-1:BW]),
    .wr_data_i (resp),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (window)
  );

  assign reqcyc    = (state_q == ST_REQ);
  assign req       = req_addr_q;
  assign respack   = respcyc & ~reset;
  assign win_bytes = window;
  assign win_count = (occ_q > OW'(WIN_BYTES)) ? 4'(WIN_BYTES) : occ_q[3:0];
  assign win_rip   = win_rip_q;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end that sits directly upstream of the decoder in `Core`. It issues 64-byte line reads on the system bus and absorbs the 8-byte response beats into a 128-byte circular byte queue. It then presents a 15-byte window, starting at the current decode RIP, to the decoder. The decoder consumes 0–15 bytes per cycle; a redirect flushes the queue and restarts fetch at a new RIP.

## Interface
Parameters:
- `BUF_BYTES`, 128, queue capacity in bytes (power of two, ≥ 2 lines)
- `WIN_BYTES`, 15, decoder window width in bytes
- `LINE_BYTES`, 64, bytes per bus request (8 beats of 8 bytes)

Ports:
- `clk`  in  1  system clock (the bus clock); one clock domain
- `reset`  in  1  synchronous, active-high
- `entry`  in  64  start RIP, sampled while `reset` is high
- `redirect`  in  1  flush queue and refetch from `redirect_rip`
- `redirect_rip`  in  64  new fetch/decode RIP
- `reqcyc`  out  1  read request valid
- `req`  out  64  line address, always `& ~63`
- `reqack`  in  1  bus accepted the request
- `respcyc`  in  1  response beat valid
- `resp`  in  64  beat data; byte k is at bits [8k+7:8k] (little-endian)
- `respack`  out  1  beat accepted
- `win_bytes`  out  120  window; byte 0 at [7:0]
- `win_count`  out  4  valid window bytes, min(occupancy, 15)
- `win_rip`  out  64  RIP of window byte 0
- `consume`  in  4  bytes the decoder retires this cycle, 0–15

## Operation
- Queue state: `rd_ptr`, `wr_ptr` (7-bit, wrap mod 128) and `occ` (8-bit, 0–128). `wr_ptr` is always a multiple of 8.
- FSM states: IDLE, REQ, RESP.
  - IDLE→REQ when `occ ≤ BUF_BYTES − LINE_BYTES` and no redirect this cycle.
  - REQ holds `reqcyc=1` with a stable `req` until `reqack`, then goes to RESP.
  - RESP counts beats 0–7 on `respcyc`; gaps between beats are allowed. After beat 7 it returns to IDLE and `line_rip += 64`.
- `respack = respcyc` whenever not in reset. Space for a full line is guaranteed at issue time.
- Skip: after reset or redirect to RIP r, the first line sets `skip_beats = r[5:3]`. Beats with index < `skip_beats` are discarded. The beat at index r[5:3] is written whole, and `rd_ptr` is set to `wr_ptr_at_that_beat + r[2:0]`; `occ` counts only bytes at or after r.
- Each accepted beat writes 8 bytes at `wr_ptr`, then `wr_ptr += 8`.
- Consume: `rd_ptr += consume`, `win_rip += consume`, `occ += written − consume`.
  - `consume > win_count` is illegal and triggers an assertion `$fatal`.
- Redirect takes priority over fill and consume in the same cycle:
  - `occ=0`, `rd_ptr=wr_ptr=0`, `win_rip=redirect_rip`, `line_rip=redirect_rip & ~63`, skip reloaded.
  - In REQ, `reqcyc` stays high until `reqack`, and the stale line's 8 beats are then accepted and discarded (`stale` flag).
  - In RESP, the remaining beats of the stale line are discarded the same way.
  - The new line is requested only after the FSM returns to IDLE.
- A second redirect while `stale` is set only updates the RIPs; `stale` stays set.

## Timing
- Reset values: `reqcyc=0`, `req=0`, `respack=0`, `win_count=0`, `win_rip=entry`, FSM=IDLE, `occ=0`, `stale=0`.
- `reqcyc` rises the cycle after IDLE with space; earliest is the first cycle after reset deasserts.
- A beat accepted in cycle t is visible in `win_bytes`/`win_count` at t+1. The window is driven combinationally from registered queue state; there is no bypass.
- The window wraps across the queue end, so bytes at indices 127 and 0 can be contiguous.
- Fill and consume in the same cycle are both applied, and `occ` stays exact.
- Reset mid-burst: all state returns to reset values immediately. Beats arriving after reset deasserts, still belonging to the prior line, are the bus's responsibility; Sysbus guarantees none.

## Structure
- `fetch_pkg`: `fetch_state_t` enum, `LINE_BYTES`, `BEAT_BYTES=8`, `BEATS_PER_LINE=8`, and the window typedef `logic[14:0][7:0]`.
- One natural sub-module: `fetch_byte_ring`, the 128-byte storage with an 8-byte aligned write port and a 15-byte wrapping read port.
- The FSM, pointers and skip/stale logic live in `fetch_queue`.

## Test plan
- Reset with `entry=0x1000`, bus returns bytes 0x00..0x3F → `req=0x1000`; after 8 beats, `win_count=15`, `win_bytes` byte 0 = 0x00, `win_rip=0x1000`.
- `entry=0x100D` → beat 0 dropped; beat 1 written; window byte 0 = 0x0D, `occ=51` after the line.
- Decoder consumes 15 every cycle on a 1-cycle-latency bus → no overrun; `req` steps 0x1000, 0x1040, 0x1080; `reqcyc` low while `occ>64`.
- Redirect to 0x2008 at beat 3 of the 0x1000 line → beats 4–7 discarded; next `req=0x2000`; window byte 0 = byte 8 of that line.
- Fill and `consume=5` in the same cycle with `occ=10` → `occ=13`, `win_rip` advances by 5.
- `rd_ptr` near 124 with 15 valid bytes → window correctly spans indices 124–127 and 0–10.
